// File: rtl/bcd_disp_pkg.sv
// Shared BCD digit type and 7-segment encoding for the HEX display counter.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg7_t;

    localparam bcd_digit_t BCD_MAX   = 4'd9;
    localparam bcd_digit_t BCD_ZERO  = 4'd0;

    localparam seg7_t SEG_0     = 7'h40;
    localparam seg7_t SEG_1     = 7'h79;
    localparam seg7_t SEG_2     = 7'h24;
    localparam seg7_t SEG_3     = 7'h30;
    localparam seg7_t SEG_4     = 7'h19;
    localparam seg7_t SEG_5     = 7'h12;
    localparam seg7_t SEG_6     = 7'h02;
    localparam seg7_t SEG_7     = 7'h78;
    localparam seg7_t SEG_8     = 7'h00;
    localparam seg7_t SEG_9     = 7'h10;
    localparam seg7_t SEG_BLANK = 7'h7F;

    function automatic seg7_t seg7_decode(input bcd_digit_t d);
        seg7_t s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Non-decimal nibbles are coerced to zero so the count never holds an illegal digit.
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_ZERO : d;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by CLK_HZ/TICK_HZ while enabled; tick marks the last cycle of each period.
// clr restarts the period and masks the tick in the cycle it is asserted.
module tick_prescaler #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);
    assign tick      = en && !clr && w_at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter stepped by an internal prescaler, with
// per-digit 7-segment outputs, optional leading-zero blanking and a wrap strobe.
module bcd_tick_counter
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1_000_000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  tick,
    output logic                  wrap
);

    logic                w_tick;
    logic [4*DIGITS-1:0] w_bcd;
    logic [DIGITS-1:0]   w_step;
    logic                w_rollover;
    logic [DIGITS-1:0]   w_blank;
    logic                r_wrap;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (w_tick)
    );

    // Ripple carry/borrow: digit k steps when every lower digit sits at its limit.
    always_comb begin
        logic v_c;
        w_step = '0;
        v_c    = w_tick;
        for (int k = 0; k < DIGITS; k++) begin
            w_step[k] = v_c;
            if (up) begin
                v_c = v_c && (w_bcd[4*k +: 4] == BCD_MAX);
            end else begin
                v_c = v_c && (w_bcd[4*k +: 4] == BCD_ZERO);
            end
        end
        w_rollover = v_c;
    end

    // Digit k blanks when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        logic v_z;
        w_blank = '0;
        v_z     = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            v_z = v_z && (w_bcd[4*k +: 4] == BCD_ZERO);
            if (BLANK_LZ && (k > 0)) begin
                w_blank[k] = v_z;
            end
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_t r_digit;
        bcd_digit_t w_next;

        always_comb begin
            if (up) begin
                w_next = (r_digit == BCD_MAX) ? BCD_ZERO : r_digit + 4'd1;
            end else begin
                w_next = (r_digit == BCD_ZERO) ? BCD_MAX : r_digit - 4'd1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_digit <= BCD_ZERO;
            end else if (load) begin
                r_digit <= bcd_sanitize(load_val[4*k +: 4]);
            end else if (w_step[k]) begin
                r_digit <= w_next;
            end
        end

        assign w_bcd[4*k +: 4] = r_digit;
        assign seg[7*k +: 7]   = w_blank[k] ? SEG_BLANK : seg7_decode(r_digit);
    end

    // w_rollover is already gated by tick, so a load cycle can never raise wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_rollover;
        end
    end

    assign bcd  = w_bcd;
    assign tick = w_tick;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter: DIGITS=2, DIV=10, one plain and one blanking instance.
module tb_bcd_tick_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  bcd,   bcd_b;
    logic [13:0] seg,   seg_b;
    logic        tick,  tick_b;
    logic        wrap,  wrap_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_tick_counter #(
        .DIGITS(2), .CLK_HZ(10), .TICK_HZ(1), .BLANK_LZ(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd), .seg(seg), .tick(tick), .wrap(wrap)
    );

    bcd_tick_counter #(
        .DIGITS(2), .CLK_HZ(10), .TICK_HZ(1), .BLANK_LZ(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd_b), .seg(seg_b), .tick(tick_b), .wrap(wrap_b)
    );

    typedef struct {
        logic [7:0]  val;
        logic [7:0]  exp_bcd;
        logic [13:0] exp_seg;
        logic [13:0] exp_seg_b;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the 1-based cycle index at which tick is visible, or -1 on timeout.
    task automatic wait_tick(input int max, output int n);
        n = 1;
        while (tick !== 1'b1 && n < max) begin
            step();
            n++;
        end
        if (tick !== 1'b1) n = -1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        step();
        load     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic held;

        vecs[0] = '{8'h00, 8'h00, {7'h40, 7'h40}, {7'h7F, 7'h40}};
        vecs[1] = '{8'h12, 8'h12, {7'h79, 7'h24}, {7'h79, 7'h24}};
        vecs[2] = '{8'h34, 8'h34, {7'h30, 7'h19}, {7'h30, 7'h19}};
        vecs[3] = '{8'h56, 8'h56, {7'h12, 7'h02}, {7'h12, 7'h02}};
        vecs[4] = '{8'h78, 8'h78, {7'h78, 7'h00}, {7'h78, 7'h00}};
        vecs[5] = '{8'h09, 8'h09, {7'h40, 7'h10}, {7'h7F, 7'h10}};
        vecs[6] = '{8'h4A, 8'h40, {7'h19, 7'h40}, {7'h19, 7'h40}};
        vecs[7] = '{8'hF3, 8'h03, {7'h40, 7'h30}, {7'h7F, 7'h30}};
        vecs[8] = '{8'h90, 8'h90, {7'h10, 7'h40}, {7'h10, 7'h40}};

        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        #12;
        chk("rst_bcd",    bcd,   8'h00);
        chk("rst_tick",   tick,  1'b0);
        chk("rst_wrap",   wrap,  1'b0);
        chk("rst_seg",    seg,   {7'h40, 7'h40});
        chk("rst_seg_b",  seg_b, {7'h7F, 7'h40});
        chk("rst_tick_b", tick_b, 1'b0);
        chk("rst_wrap_b", wrap_b, 1'b0);

        // 1: free count from reset
        step();
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            chk($sformatf("t1_tick_c%0d", c), tick, (c % 10) == 0);
            chk($sformatf("t1_wrap_c%0d", c), wrap, 1'b0);
            step();
        end
        chk("t1_bcd",   bcd,   8'h10);
        chk("t1_seg",   seg,   {7'h79, 7'h40});
        chk("t1_seg_b", seg_b, {7'h79, 7'h40});

        // 2: up-count rollover
        do_load(8'h98);
        chk("t2_load", bcd, 8'h98);
        wait_tick(30, n);
        chk("t2_period1", n, 10);
        step();
        chk("t2_bcd99", bcd, 8'h99);
        chk("t2_nowrap", wrap, 1'b0);
        wait_tick(30, n);
        chk("t2_period2", n, 10);
        step();
        chk("t2_bcd00", bcd, 8'h00);
        chk("t2_wrap", wrap, 1'b1);
        chk("t2_seg_b", seg_b, {7'h7F, 7'h40});
        step();
        chk("t2_wrap_end", wrap, 1'b0);

        // 3: down-count borrow through all digits
        up = 1'b0;
        do_load(8'h00);
        wait_tick(30, n);
        step();
        chk("t3_bcd99", bcd, 8'h99);
        chk("t3_wrap", wrap, 1'b1);
        step();
        chk("t3_wrap_end", wrap, 1'b0);
        wait_tick(30, n);
        step();
        chk("t3_bcd98", bcd, 8'h98);

        // 4: load coinciding with a tick that would otherwise wrap
        do_load(8'h00);
        wait_tick(30, n);
        chk("t4_tick_seen", tick, 1'b1);
        load = 1'b1; load_val = 8'h4A;
        #1;
        chk("t4_tick_masked", tick, 1'b0);
        step();
        load = 1'b0;
        chk("t4_bcd", bcd, 8'h40);
        chk("t4_nowrap", wrap, 1'b0);
        wait_tick(30, n);
        chk("t4_period", n, 10);
        step();
        chk("t4_bcd39", bcd, 8'h39);

        // 5: enable pause mid-period keeps the prescaler phase
        for (int i = 0; i < 5; i++) step();
        en   = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bcd !== 8'h39 || tick !== 1'b0) held = 1'b0;
            step();
        end
        chk("t5_hold", held, 1'b1);
        en = 1'b1;
        wait_tick(30, n);
        chk("t5_resume", n, 5);
        step();
        chk("t5_bcd38", bcd, 8'h38);

        // 6: blanking, then asynchronous reset while tick is high
        en = 1'b0; up = 1'b1;
        do_load(8'h07);
        chk("t6_seg_b", seg_b, {7'h7F, 7'h78});
        chk("t6_seg",   seg,   {7'h40, 7'h78});
        chk("t6_bcd_b", bcd_b, 8'h07);
        en = 1'b1;
        wait_tick(30, n);
        chk("t6_period", n, 10);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_bcd",   bcd,   8'h00);
        chk("t6_rst_tick",  tick,  1'b0);
        chk("t6_rst_seg_b", seg_b, {7'h7F, 7'h40});
        step();
        rst = 1'b0;
        wait_tick(30, n);
        chk("t6_first_tick", n, 10);
        chk("t6_bcd_pre", bcd, 8'h00);

        // Decode/load table with counting frozen
        en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_load(vecs[i].val);
            chk($sformatf("tbl%0d_bcd", i),   bcd,   vecs[i].exp_bcd);
            chk($sformatf("tbl%0d_bcd_b", i), bcd_b, vecs[i].exp_bcd);
            chk($sformatf("tbl%0d_seg", i),   seg,   vecs[i].exp_seg);
            chk($sformatf("tbl%0d_seg_b", i), seg_b, vecs[i].exp_seg_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Parametrised multi-digit BCD up/down counter with a built-in tick prescaler and per-digit 7-segment decode, driving the board's HEX displays directly. It generalises the fixed two-digit 0–99 counter-plus-divider arrangement. It adds the following:
- configurable digit count and tick rate;
- count direction;
- synchronous parallel load;
- optional leading-zero blanking;
- a wrap strobe.

It sits between the board clock and the HEX outputs, with control bits taken from synchronised switches and keys.

## Interface
- DIGITS, 2, number of BCD digits (1–6); count range 0 to 10^DIGITS − 1
- CLK_HZ, 50_000_000, input clock frequency
- TICK_HZ, 1_000_000, count rate; DIV = CLK_HZ / TICK_HZ, must be ≥ 2 and an exact integer
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 is always shown)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable; low freezes prescaler and count
- up  in  1  1 = increment, 0 = decrement
- load  in  1  synchronous load strobe
- load_val  in  4*DIGITS  BCD value to load; digit k at [4k+3:4k]
- bcd  out  4*DIGITS  current count, BCD
- seg  out  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit, digit k at [7k+6:7k]
- tick  out  1  one-cycle prescaler strobe
- wrap  out  1  one-cycle strobe on rollover

## Operation
- **Reset values:** while rst is high, or after it, the prescaler is 0, bcd = 0, tick = 0, wrap = 0. seg shows "0" on digit 0 (7'h40). Other digits show 7'h40, or 7'h7F when BLANK_LZ = 1.
- **Prescaler:** counts 0 … DIV−1 only while en = 1.
  - tick = 1 in the cycle the prescaler equals DIV−1 and en = 1; the prescaler then returns to 0.
- **Count step:** on a clock edge where tick = 1, bcd steps by ±1 in BCD. Per-digit carry/borrow: 9→0 carries up, 0→9 borrows.
- **Wrap:**
  - Up from all-9s goes to all-0s, and wrap = 1 for the following cycle.
  - Down from all-0s goes to all-9s, and wrap = 1 for the following cycle.
- **Load:**
  - load = 1 has priority over tick. It sets bcd = load_val, clears the prescaler, and suppresses tick and wrap for that cycle.
  - load works regardless of en.
  - A load_val digit > 9 loads as 0.
- **Direction change:** up may change in any cycle and takes effect on the next tick. No state besides the sampled value is involved.
- **Segment decode:** combinational from the registered bcd. Codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- **Blanking (BLANK_LZ = 1):** digit k > 0 shows 7F when it and all higher digits are 0.

## Timing
- bcd changes on the rising edge that samples tick = 1. seg follows in the same cycle, combinationally.
- First tick after reset release with en = 1: the DIV-th enabled cycle.
- tick and wrap are registered-state derived. wrap is registered: asserted in the cycle after the rollover edge, for exactly 1 cycle.
- load takes effect at the sampling edge; bcd shows load_val from the next cycle.
- Reset asserted mid-count clears all state immediately; it does not wait for clk.
- en deassert mid-period holds the prescaler value. Resuming continues from that value rather than restarting.

## Structure
- **Package `bcd_disp_pkg`:**
  - 7-segment code constants (SEG_0 … SEG_9, SEG_BLANK);
  - a `bcd_digit_t` 4-bit typedef;
  - a `seg7_decode` function.
- **Sub-module `tick_prescaler`:** holds the prescaler. Parameters CLK_HZ, TICK_HZ. Ports clk, rst, en, clr, tick.
- **Top:** digit chain and blanking logic, built with a generate loop over DIGITS.

## Test plan
Bench parameters: DIGITS = 2, CLK_HZ = 10, TICK_HZ = 1 (DIV = 10).
1. Reset then en = 1, up = 1 for 100 cycles → tick on cycles 10, 20, …; bcd reaches 8'h10; seg = {79, 40}.
2. load 8'h98, up = 1, run 2 ticks → bcd goes 99 then 00; wrap high for exactly 1 cycle after the 99→00 edge.
3. load 8'h00, up = 0, one tick → bcd = 8'h99, wrap pulses; next tick → 8'h98.
4. load and tick coincide, load_val = 8'h4A → bcd = 8'h40 (the invalid digit loads as 0); no wrap; the next tick comes 10 enabled cycles later.
5. en dropped at prescaler = 5 for 20 cycles, then raised → next tick 5 enabled cycles later; bcd unchanged while en is low.
6. BLANK_LZ = 1, bcd = 8'h07 → seg[13:7] = 7F, seg[6:0] = 78. Assert rst mid-period → bcd = 0 and tick = 0 immediately.
